// File: rtl/m92_sdr_cpu_arbiter_if.sv
// ---------------------------------------------------------------------------
// m92_sdr_cpu_arbiter_if : CPU port A/B, SDRAM toggle-channel bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface m92_sdr_cpu_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [1:0]        a_wr_sel;
  logic [DATA_W-1:0] a_dout;
  logic              a_busy;
  logic              a_done;

  logic              b_en;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic [1:0]        b_wr_sel;
  logic [DATA_W-1:0] b_dout;
  logic              b_busy;
  logic              b_done;

  logic              ovr;

  logic              sdr_rq;
  logic              sdr_ack;
  logic [ADDR_W-1:0] sdr_addr;
  logic [DATA_W-1:0] sdr_din;
  logic [1:0]        sdr_wr_sel;
  logic [DATA_W-1:0] sdr_dout;

  modport slave (
    input  a_req, a_addr, a_din, a_wr_sel,
    output a_dout, a_busy, a_done,
    input  b_en, b_req, b_addr, b_din, b_wr_sel,
    output b_dout, b_busy, b_done,
    output ovr,
    output sdr_rq, sdr_addr, sdr_din, sdr_wr_sel,
    input  sdr_ack, sdr_dout
  );

  modport master (
    output a_req, a_addr, a_din, a_wr_sel,
    input  a_dout, a_busy, a_done,
    output b_en, b_req, b_addr, b_din, b_wr_sel,
    input  b_dout, b_busy, b_done,
    input  ovr,
    input  sdr_rq, sdr_addr, sdr_din, sdr_wr_sel,
    output sdr_ack, sdr_dout
  );
endinterface

`default_nettype wire

// File: rtl/m92_sdr_cpu_arbiter.sv
// ---------------------------------------------------------------------------
// m92_sdr_cpu_arbiter : shares the CPU SDRAM toggle channel between V30 (A) and sound CPU (B)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m92_sdr_cpu_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
) (
  input  logic                 CLK_32M,
  input  logic                 reset_n,
  m92_sdr_cpu_arbiter_if.slave bus
);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;

  logic              sdr_rq_q;
  logic [ADDR_W-1:0] sdr_addr_q;
  logic [DATA_W-1:0] sdr_din_q;
  logic [1:0]        sdr_sel_q;

  logic [DATA_W-1:0] a_dout_q;
  logic [DATA_W-1:0] b_dout_q;
  logic              a_done_q;
  logic              b_done_q;
  logic              ovr_q;

  logic              a_pend_q;
  logic [ADDR_W-1:0] a_pend_addr_q;
  logic [DATA_W-1:0] a_pend_din_q;
  logic [1:0]        a_pend_sel_q;
  logic              b_pend_q;
  logic [ADDR_W-1:0] b_pend_addr_q;
  logic [DATA_W-1:0] b_pend_din_q;
  logic [1:0]        b_pend_sel_q;

  logic              owner_q;   // 0 = A, 1 = B
  logic              tie_b_q;   // B wins the next tie

  logic              w_ack_match;
  logic              w_idle;
  logic              w_wait;
  logic              w_a_held;
  logic              w_b_held;
  logic              w_a_take;
  logic              w_b_take;
  logic              w_a_cand;
  logic              w_b_cand;
  logic              w_tie;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_gnt;
  logic              w_complete;
  logic              w_ovr_set;
  logic              w_a_busy;
  logic              w_b_busy;
  logic [ADDR_W-1:0] w_src_addr;
  logic [DATA_W-1:0] w_src_din;
  logic [1:0]        w_src_sel;

  assign w_ack_match = (bus.sdr_ack == sdr_rq_q);

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:  if (w_ack_match) state_d = S_IDLE;
      S_IDLE:  if (w_gnt)       state_d = S_WAIT;
      S_WAIT:  if (w_ack_match) state_d = S_IDLE;
      default:                  state_d = S_SYNC;
    endcase
  end

  always_comb begin
    w_idle     = (state_q == S_IDLE);
    w_wait     = (state_q == S_WAIT);
    // A port is "held" by an earlier request until its completion edge
    w_a_held   = a_pend_q | (w_wait & ~owner_q);
    w_b_held   = b_pend_q | (w_wait &  owner_q);
    w_a_take   = bus.a_req & ~w_a_held;
    w_b_take   = bus.b_req & bus.b_en & ~w_b_held;
    w_a_cand   = w_a_take | a_pend_q;
    w_b_cand   = (w_b_take | b_pend_q) & bus.b_en;
    w_tie      = w_idle & w_a_cand & w_b_cand;
    w_gnt_a    = w_idle & w_a_cand & (~w_b_cand | ~tie_b_q);
    w_gnt_b    = w_idle & w_b_cand & (~w_a_cand |  tie_b_q);
    w_gnt      = w_gnt_a | w_gnt_b;
    w_complete = w_wait & w_ack_match;
    w_ovr_set  = (bus.a_req & w_a_held) | (bus.b_req & bus.b_en & w_b_held);
    w_a_busy   = bus.a_req | w_a_held;
    w_b_busy   = bus.b_req | w_b_held;

    w_src_addr = bus.a_addr;
    w_src_din  = bus.a_din;
    w_src_sel  = bus.a_wr_sel;
    if (w_gnt_b) begin
      if (b_pend_q) begin
        w_src_addr = b_pend_addr_q;
        w_src_din  = b_pend_din_q;
        w_src_sel  = b_pend_sel_q;
      end else begin
        w_src_addr = bus.b_addr;
        w_src_din  = bus.b_din;
        w_src_sel  = bus.b_wr_sel;
      end
    end else if (a_pend_q) begin
      w_src_addr = a_pend_addr_q;
      w_src_din  = a_pend_din_q;
      w_src_sel  = a_pend_sel_q;
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      sdr_rq_q   <= 1'b0;
      sdr_addr_q <= '0;
      sdr_din_q  <= '0;
      sdr_sel_q  <= 2'b00;
      owner_q    <= 1'b0;
      tie_b_q    <= 1'b0;
    end else begin
      if (w_gnt) begin
        sdr_rq_q   <= ~sdr_rq_q;
        sdr_addr_q <= w_src_addr;
        sdr_din_q  <= w_src_din;
        sdr_sel_q  <= w_src_sel;
        owner_q    <= w_gnt_b;
      end
      // The pointer only moves on contended grants, so ties alternate A, B, A...
      if (w_tie) begin
        tie_b_q <= ~tie_b_q;
      end
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      a_done_q <= w_complete & ~owner_q;
      b_done_q <= w_complete &  owner_q;
      if (w_complete && (sdr_sel_q == 2'b00)) begin
        if (owner_q) begin
          b_dout_q <= bus.sdr_dout;
        end else begin
          a_dout_q <= bus.sdr_dout;
        end
      end
      if (w_ovr_set) begin
        ovr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      a_pend_q      <= 1'b0;
      a_pend_addr_q <= '0;
      a_pend_din_q  <= '0;
      a_pend_sel_q  <= 2'b00;
      b_pend_q      <= 1'b0;
      b_pend_addr_q <= '0;
      b_pend_din_q  <= '0;
      b_pend_sel_q  <= 2'b00;
    end else begin
      if (w_gnt_a) begin
        a_pend_q <= 1'b0;
      end else if (w_a_take) begin
        a_pend_q      <= 1'b1;
        a_pend_addr_q <= bus.a_addr;
        a_pend_din_q  <= bus.a_din;
        a_pend_sel_q  <= bus.a_wr_sel;
      end
      if (!bus.b_en || w_gnt_b) begin
        b_pend_q <= 1'b0;
      end else if (w_b_take) begin
        b_pend_q      <= 1'b1;
        b_pend_addr_q <= bus.b_addr;
        b_pend_din_q  <= bus.b_din;
        b_pend_sel_q  <= bus.b_wr_sel;
      end
    end
  end

  assign bus.a_dout     = a_dout_q;
  assign bus.b_dout     = b_dout_q;
  assign bus.a_done     = a_done_q;
  assign bus.b_done     = b_done_q;
  assign bus.a_busy     = w_a_busy;
  assign bus.b_busy     = w_b_busy;
  assign bus.ovr        = ovr_q;
  assign bus.sdr_rq     = sdr_rq_q;
  assign bus.sdr_addr   = sdr_addr_q;
  assign bus.sdr_din    = sdr_din_q;
  assign bus.sdr_wr_sel = sdr_sel_q;

endmodule

`default_nettype wire
